// File: rtl/rr_arbiter3.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter3
//  Purpose  : Three-requester round-robin arbiter with registered one-hot
//             grant, per-ownership hold timeout and a mandatory dead cycle
//             between owners.
//  Ports    : clk     - rising-edge clock
//             rst_n   - asynchronous active-low reset
//             REQ     - request lines, REQ[i] held high while i wants access
//             GNT     - registered one-hot grant, or 3'b000
//             OWNER   - index of granted requester, 2'b11 when none
//             ANY     - combinational OR of REQ
//             TIMEOUT - one-cycle pulse during the gap after a forced revoke
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter3 #(
    parameter int MAX_HOLD = 8,   // 0 disables the hold timeout
    parameter int CNT_W    = 4    // must satisfy 2**CNT_W > MAX_HOLD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] REQ,
    output logic [2:0] GNT,
    output logic [1:0] OWNER,
    output logic       ANY,
    output logic       TIMEOUT
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_grant = 2'd1;
    localparam logic [1:0] c_st_gap   = 2'd2;

    localparam logic [1:0] c_no_owner = 2'b11;
    localparam bit         c_tmo_en   = (MAX_HOLD != 0);
    // Count value seen in the last permitted GRANT cycle; unused when the
    // timeout is disabled.
    localparam logic [CNT_W-1:0] c_hold_last =
        CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    logic [1:0]       r_state;
    logic [1:0]       r_ptr;
    logic [1:0]       r_owner;
    logic [2:0]       r_gnt;
    logic             r_timeout;
    logic [CNT_W-1:0] r_cnt;

    logic [1:0]       w_winner;
    logic [2:0]       w_winner_onehot;
    logic             w_any;
    logic             w_owner_req;
    logic [1:0]       w_ptr_next;
    logic             w_hold_expired;

    assign w_any = |REQ;

    // Search order ptr, ptr+1, ptr+2 (mod 3). The result is only used when
    // at least one request is present.
    always_comb begin
        w_winner = 2'd0;
        case (r_ptr)
            2'd1: begin
                if (REQ[1])      w_winner = 2'd1;
                else if (REQ[2]) w_winner = 2'd2;
                else             w_winner = 2'd0;
            end
            2'd2: begin
                if (REQ[2])      w_winner = 2'd2;
                else if (REQ[0]) w_winner = 2'd0;
                else             w_winner = 2'd1;
            end
            default: begin
                if (REQ[0])      w_winner = 2'd0;
                else if (REQ[1]) w_winner = 2'd1;
                else             w_winner = 2'd2;
            end
        endcase
    end

    assign w_winner_onehot = 3'(3'b001 << w_winner);

    // Explicit mux keeps the 2'b11 "no owner" code from indexing past REQ.
    always_comb begin
        w_owner_req = 1'b0;
        case (r_owner)
            2'd0:    w_owner_req = REQ[0];
            2'd1:    w_owner_req = REQ[1];
            2'd2:    w_owner_req = REQ[2];
            default: w_owner_req = 1'b0;
        endcase
    end

    assign w_ptr_next     = (r_owner == 2'd2) ? 2'd0 : r_owner + 2'd1;
    assign w_hold_expired = c_tmo_en && (r_cnt == c_hold_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_st_idle;
            r_ptr     <= 2'd0;
            r_owner   <= c_no_owner;
            r_gnt     <= 3'b000;
            r_timeout <= 1'b0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_timeout <= 1'b0;
                    if (w_any) begin
                        r_state <= c_st_grant;
                        r_owner <= w_winner;
                        r_gnt   <= w_winner_onehot;
                        r_cnt   <= '0;
                    end
                end

                c_st_grant: begin
                    // A release on the timeout edge wins, so TIMEOUT only
                    // flags a genuinely forced revoke.
                    if (!w_owner_req || w_hold_expired) begin
                        r_state   <= c_st_gap;
                        r_ptr     <= w_ptr_next;
                        r_owner   <= c_no_owner;
                        r_gnt     <= 3'b000;
                        r_timeout <= w_owner_req;
                        r_cnt     <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                c_st_gap: begin
                    r_timeout <= 1'b0;
                    if (w_any) begin
                        r_state <= c_st_grant;
                        r_owner <= w_winner;
                        r_gnt   <= w_winner_onehot;
                        r_cnt   <= '0;
                    end else begin
                        r_state <= c_st_idle;
                    end
                end

                default: begin
                    r_state   <= c_st_idle;
                    r_owner   <= c_no_owner;
                    r_gnt     <= 3'b000;
                    r_timeout <= 1'b0;
                    r_cnt     <= '0;
                end
            endcase
        end
    end

    assign GNT     = r_gnt;
    assign OWNER   = r_owner;
    assign ANY     = w_any;
    assign TIMEOUT = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter3.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rr_arbiter3
//  Purpose  : Directed self-checking bench for rr_arbiter3 (MAX_HOLD = 8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter3;

    logic       clk;
    logic       rst_n;
    logic [2:0] REQ;
    logic [2:0] GNT;
    logic [1:0] OWNER;
    logic       ANY;
    logic       TIMEOUT;

    int checks = 0;
    int errors = 0;

    rr_arbiter3 #(
        .MAX_HOLD (8),
        .CNT_W    (4)
    ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .REQ     (REQ),
        .GNT     (GNT),
        .OWNER   (OWNER),
        .ANY     (ANY),
        .TIMEOUT (TIMEOUT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Grant, owner and timeout together in one step.
    task automatic check_out(input string tag, input logic [2:0] gnt,
                             input logic [1:0] own, input logic tmo);
        check({tag, ".gnt"},   {5'd0, GNT},     {5'd0, gnt});
        check({tag, ".owner"}, {6'd0, OWNER},   {6'd0, own});
        check({tag, ".tmo"},   {7'd0, TIMEOUT}, {7'd0, tmo});
    endtask

    initial begin
        // ---------------- power-on reset ----------------
        rst_n = 1'b0;
        REQ   = 3'b000;
        #12;
        check_out("por", 3'b000, 2'b11, 1'b0);
        check("por.any", {7'd0, ANY}, 8'd0);
        rst_n = 1'b1;
        tick();
        check_out("idle0", 3'b000, 2'b11, 1'b0);

        // ---------------- single request ----------------
        REQ = 3'b100;
        check("single.any", {7'd0, ANY}, 8'd1);
        check("single.nocomb", {5'd0, GNT}, 8'd0);
        tick();                                   // edge t
        check_out("single.t1", 3'b100, 2'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("single.hold", 3'b100, 2'd2, 1'b0);
        end
        REQ = 3'b000;
        check("single.any0", {7'd0, ANY}, 8'd0);
        check("single.reg", {5'd0, GNT}, 8'h04);
        tick();                                   // edge t+4 -> GAP
        check_out("single.gap", 3'b000, 2'b11, 1'b0);
        tick();                                   // -> IDLE, ptr = 0
        check_out("single.idle", 3'b000, 2'b11, 1'b0);

        // ---------------- rotation with REQ=111 ----------------
        REQ = 3'b111;
        tick();
        check_out("rot.g0", 3'b001, 2'd0, 1'b0);
        tick(); tick();
        REQ = 3'b110;
        tick();
        check_out("rot.gap0", 3'b000, 2'b11, 1'b0);
        REQ = 3'b111;
        tick();
        check_out("rot.g1", 3'b010, 2'd1, 1'b0);
        tick(); tick();
        REQ = 3'b101;
        tick();
        check_out("rot.gap1", 3'b000, 2'b11, 1'b0);
        REQ = 3'b111;
        tick();
        check_out("rot.g2", 3'b100, 2'd2, 1'b0);
        tick(); tick();
        REQ = 3'b011;
        tick();
        check_out("rot.gap2", 3'b000, 2'b11, 1'b0);
        REQ = 3'b111;
        tick();
        check_out("rot.g3", 3'b001, 2'd0, 1'b0);
        // Move on to requester 2 with ptr = 2 for the reset test.
        REQ = 3'b110;
        tick();
        REQ = 3'b111;
        tick();
        check_out("rot.g4", 3'b010, 2'd1, 1'b0);
        REQ = 3'b101;
        tick();
        REQ = 3'b111;
        tick();
        check_out("rot.g5", 3'b100, 2'd2, 1'b0);

        // ---------------- asynchronous reset mid-grant ----------------
        #3;
        rst_n = 1'b0;
        #1;
        check_out("arst.now", 3'b000, 2'b11, 1'b0);
        check("arst.any", {7'd0, ANY}, 8'd1);
        tick();
        check_out("arst.held", 3'b000, 2'b11, 1'b0);
        #3;
        rst_n = 1'b1;
        REQ = 3'b011;
        tick();
        check_out("arst.first", 3'b001, 2'd0, 1'b0);

        // ---------------- hold timeout with REQ=011 ----------------
        for (int i = 1; i < 8; i++) begin
            tick();
            check_out("tmo.hold0", 3'b001, 2'd0, 1'b0);
        end
        tick();
        check_out("tmo.gap0", 3'b000, 2'b11, 1'b1);
        tick();
        check_out("tmo.g1", 3'b010, 2'd1, 1'b0);
        for (int i = 1; i < 8; i++) begin
            tick();
            check_out("tmo.hold1", 3'b010, 2'd1, 1'b0);
        end
        tick();
        check_out("tmo.gap1", 3'b000, 2'b11, 1'b1);
        tick();
        check_out("tmo.g2", 3'b001, 2'd0, 1'b0);

        // ---------------- release on the timeout edge ----------------
        for (int i = 1; i < 8; i++) tick();
        check_out("both.last", 3'b001, 2'd0, 1'b0);
        REQ = 3'b010;
        tick();
        check_out("both.gap", 3'b000, 2'b11, 1'b0);
        REQ = 3'b111;
        tick();
        check_out("both.ptr1", 3'b010, 2'd1, 1'b0);

        // ---------------- drain to idle ----------------
        REQ = 3'b000;
        tick();
        check_out("end.gap", 3'b000, 2'b11, 1'b0);
        tick();
        check_out("end.idle", 3'b000, 2'b11, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rr_arbiter3.md
Name: rr_arbiter3

Overview:
- Three-requester round-robin arbiter. It is the granting end of the 3-line request bus whose requests are OR-combined into a single "any request" indication.
- It accepts request lines REQ[2:0] and issues a registered one-hot grant.
- Each grant is held until the owner releases or a hold timeout expires. Priority then rotates so no requester starves.
- It sits between the three requesting units and the shared resource. The ANY output feeds downstream wake-up logic.

Parameters:
- MAX_HOLD, 8: maximum consecutive GRANT cycles per ownership. 0 disables the timeout.
- CNT_W, 4: hold counter width. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- REQ  input  3  request lines; REQ[i] is held high while requester i wants the resource
- GNT  output  3  registered one-hot grant, or 3'b000
- OWNER  output  2  index of the granted requester; 2'b11 when none
- ANY  output  1  combinational OR of REQ[2:0]
- TIMEOUT  output  1  one-cycle pulse, high during the GAP cycle that follows a forced revoke

Behaviour:
- Reset (rst_n low, takes effect asynchronously):
  - state=IDLE, GNT=3'b000, OWNER=2'b11, TIMEOUT=0, ptr=0, hold count=0.
  - ANY still follows REQ during reset.
- State IDLE:
  - GNT=0.
  - At a clock edge where REQ!=0: select the first set REQ bit searching ptr, ptr+1, ptr+2 (mod 3), then go to GRANT.
  - GNT and OWNER reflect the winner from the next cycle (1-cycle grant latency).
- State GRANT:
  - GNT=one-hot(OWNER). The hold count is 0 in the first GRANT cycle and increments by 1 each cycle.
  - Release: at an edge where REQ[OWNER]==0, go to GAP. Set ptr=(OWNER+1) mod 3, GNT=0, OWNER=2'b11.
  - Timeout: at an edge where MAX_HOLD!=0, count==MAX_HOLD-1 and REQ[OWNER]==1, go to GAP. Set ptr=(OWNER+1) mod 3 and TIMEOUT=1 for the GAP cycle. A requester is therefore granted for exactly MAX_HOLD cycles.
  - Release and timeout at the same edge count as a normal release, so TIMEOUT=0.
  - Other REQ bits changing while in GRANT have no effect.
- State GAP:
  - Lasts exactly one cycle with GNT=0, so the resource always sees a dead cycle between owners.
  - At the edge leaving GAP: if REQ!=0, arbitrate from the new ptr and go to GRANT. Otherwise go to IDLE.
  - A timed-out requester that keeps REQ high is re-granted only after the other active requesters have been served.
- Invariants: GNT has at most one bit set. OWNER==2'b11 exactly when GNT==0. The ptr value is only 0, 1 or 2.
- REQ is sampled only at clock edges. There is no combinational path from REQ to GNT.
- Reset asserted mid-grant clears GNT immediately, without waiting for a clock. After reset deasserts, arbitration restarts from ptr=0.
- The state encoding is 2 bits. The unused code must return to IDLE.

Test Plan:
- Reset: REQ=3'b111 held, rst_n pulsed low mid-cycle -> GNT=000, OWNER=11, TIMEOUT=0 immediately; ANY=1 throughout.
- Single request: REQ=3'b100 set before edge t -> GNT=100, OWNER=2 from cycle t+1. REQ dropped before edge t+4 -> GNT=000 at t+5 (GAP), IDLE at t+6.
- Rotation: REQ=3'b111 constant and each owner drops its bit for one cycle after 3 cycles of grant -> grant order 001, 010, 100, 001, with exactly one GNT=000 cycle between owners.
- Timeout (MAX_HOLD=8): REQ=3'b011 held continuously -> GNT=001 for exactly 8 cycles, one GAP cycle with TIMEOUT=1, then GNT=010 for 8 cycles, GAP with TIMEOUT=1, then GNT=001.
- Simultaneous release and timeout: REQ[0] drops on the edge where the count reaches 7 -> GAP with TIMEOUT=0, ptr=1.
- Reset mid-operation: during GRANT to requester 2 with ptr=2, rst_n low -> GNT=000 immediately. After release with REQ=3'b111 -> first grant is 001 (ptr=0).
